// File: rtl/lsu_byte_seq_if.sv
// rtl/lsu_byte_seq_if.sv - core-side request/response bundle of the byte load/store sequencer
interface lsu_byte_seq_if #(
  parameter int AW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/lsu_byte_seq.sv
// rtl/lsu_byte_seq.sv - splits byte/half/word loads and stores into little-endian byte memory cycles
module lsu_byte_seq #(
  parameter int AW              = 32,
  parameter bit ERR_ON_MISALIGN = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  lsu_byte_seq_if.slave req_if,
  output logic [AW-1:0] mem_ra,
  input  logic [31:0]   mem_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_wa,
  output logic [31:0]   mem_wd
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d, last_q, last_d, size_q, size_d;
  logic          we_q, we_d, uns_q, uns_d;
  logic [AW-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [31:0]   wdata_q, wdata_d, lanes_q, lanes_d, rdata_q, rdata_d;
  logic [7:0]    wbyte_q, wbyte_d;
  logic          mem_we_q, mem_we_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [1:0]    cnt_inc;
  logic [31:0]   lanes_fill, wdata_next;
  logic          req_err;
  logic          unused_rd;

  assign unused_rd = ^mem_rd[31:8];

  function automatic logic [31:0] extend(input logic [31:0] l, input logic [1:0] sz, input logic uns);
    case (sz)
      2'd0:    extend = {{24{~uns & l[7]}}, l[7:0]};
      2'd1:    extend = {{16{~uns & l[15]}}, l[15:0]};
      default: extend = l;
    endcase
  endfunction

  always_comb begin
    cnt_inc    = cnt_q + 2'd1;
    lanes_fill = (lanes_q & ~(32'hFF << {cnt_q, 3'b000})) | ({24'h0, mem_rd[7:0]} << {cnt_q, 3'b000});
    wdata_next = wdata_q >> {cnt_inc, 3'b000};
    // Illegal size always errors; misalignment only when the parameter asks for it.
    req_err    = (req_if.req_size == 2'd3) ||
                 (ERR_ON_MISALIGN && ((req_if.req_size == 2'd1 && req_if.req_addr[0]) ||
                                      (req_if.req_size == 2'd2 && req_if.req_addr[1:0] != 2'd0)));
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    size_d       = size_q;
    we_d         = we_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lanes_d      = lanes_q;
    rdata_d      = rdata_q;
    maddr_d      = maddr_q;
    wbyte_d      = wbyte_q;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_if.req_valid) begin
          we_d    = req_if.req_we;
          size_d  = req_if.req_size;
          uns_d   = req_if.req_unsigned;
          addr_d  = req_if.req_addr;
          wdata_d = req_if.req_wdata;
          if (req_err) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = 32'h0;
          end else begin
            state_d  = S_ACCESS;
            cnt_d    = 2'd0;
            last_d   = (req_if.req_size == 2'd0) ? 2'd0 : (req_if.req_size == 2'd1) ? 2'd1 : 2'd3;
            lanes_d  = 32'h0;
            maddr_d  = req_if.req_addr;
            mem_we_d = req_if.req_we;
            wbyte_d  = req_if.req_wdata[7:0];
          end
        end
      end
      S_ACCESS: begin
        if (!we_q) lanes_d = lanes_fill;
        if (cnt_q == last_q) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          rdata_d      = we_q ? 32'h0 : extend(lanes_fill, size_q, uns_q);
        end else begin
          cnt_d    = cnt_inc;
          maddr_d  = addr_q + AW'(cnt_inc);
          mem_we_d = we_q;
          wbyte_d  = wdata_next[7:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 2'd0;
      last_q       <= 2'd0;
      size_q       <= 2'd0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      lanes_q      <= 32'h0;
      rdata_q      <= 32'h0;
      maddr_q      <= '0;
      wbyte_q      <= 8'h0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      size_q       <= size_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lanes_q      <= lanes_d;
      rdata_q      <= rdata_d;
      maddr_q      <= maddr_d;
      wbyte_q      <= wbyte_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_if.req_ready  = (state_q == S_IDLE);
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_err   = resp_err_q;
  assign req_if.resp_rdata = rdata_q;
  assign mem_ra            = maddr_q;
  assign mem_wa            = maddr_q;
  assign mem_we            = mem_we_q;
  assign mem_wd            = {24'h0, wbyte_q};
endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb/tb_lsu_byte_seq.sv - randomized and directed checks of lsu_byte_seq against a transaction-level model
module tb_lsu_byte_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_run = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_ra0, mem_wa0, mem_wd0, mem_rd0, mem_ra1, mem_wa1, mem_wd1, mem_rd1;
  logic        mem_we0, mem_we1;
  logic [7:0]  mem0 [4096];
  logic [7:0]  mem1 [4096];
  logic [7:0]  ref_mem [2][4096];
  logic [64:0] wlog [$];
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  lsu_byte_seq_if #(.AW(32)) bif0 ();
  lsu_byte_seq_if #(.AW(32)) bif1 ();

  assign bif0.req_valid = req_valid & ~sel;
  assign bif1.req_valid = req_valid & sel;
  assign bif0.req_we = req_we;             assign bif1.req_we = req_we;
  assign bif0.req_size = req_size;         assign bif1.req_size = req_size;
  assign bif0.req_unsigned = req_unsigned; assign bif1.req_unsigned = req_unsigned;
  assign bif0.req_addr = req_addr;         assign bif1.req_addr = req_addr;
  assign bif0.req_wdata = req_wdata;       assign bif1.req_wdata = req_wdata;
  assign req_ready  = sel ? bif1.req_ready  : bif0.req_ready;
  assign resp_valid = sel ? bif1.resp_valid : bif0.resp_valid;
  assign resp_err   = sel ? bif1.resp_err   : bif0.resp_err;
  assign resp_rdata = sel ? bif1.resp_rdata : bif0.resp_rdata;

  lsu_byte_seq #(.AW(32), .ERR_ON_MISALIGN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .req_if(bif0),
    .mem_ra(mem_ra0), .mem_rd(mem_rd0), .mem_we(mem_we0), .mem_wa(mem_wa0), .mem_wd(mem_wd0)
  );
  lsu_byte_seq #(.AW(32), .ERR_ON_MISALIGN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .req_if(bif1),
    .mem_ra(mem_ra1), .mem_rd(mem_rd1), .mem_we(mem_we1), .mem_wa(mem_wa1), .mem_wd(mem_wd1)
  );

  // Byte memories: async read with junk in the upper bits, sync write; 4 KiB window aliases the address space.
  function automatic logic [7:0] init_byte(input int a);
    return 8'(a * 37 + 11 + (a >> 8));
  endfunction

  assign mem_rd0 = {24'hA5C35A, mem0[mem_ra0[11:0]]};
  assign mem_rd1 = {24'h5AC3A5, mem1[mem_ra1[11:0]]};

  always @(posedge clk) begin
    if (init_run) begin
      for (int a = 0; a < 4096; a++) begin
        mem0[a] <= init_byte(a);
        mem1[a] <= init_byte(a);
      end
    end else begin
      if (mem_we0) mem0[mem_wa0[11:0]] <= mem_wd0[7:0];
      if (mem_we1) mem1[mem_wa1[11:0]] <= mem_wd1[7:0];
    end
  end

  always @(negedge clk) begin
    if (mem_we0) wlog.push_back({1'b0, mem_wa0, mem_wd0});
    if (mem_we1) wlog.push_back({1'b1, mem_wa1, mem_wd1});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input logic [64:0] exp_w [$]);
    chk("wr_count", 64'(wlog.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++) begin
      chk("wr_addr", 64'(wlog[i][64:32]), 64'(exp_w[i][64:32]));
      chk("wr_data", 64'(wlog[i][31:0]), 64'(exp_w[i][31:0]));
    end
    wlog.delete();
  endtask

  task automatic do_txn(input logic d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          n, lat, cyc;
    logic        err;
    logic [31:0] a, exp_rd;
    logic [64:0] exp_w [$];
    n      = 1 << int'(size);
    err    = (size == 2'd3) || (d && (addr % 32'(n)) != 0);
    exp_rd = 32'h0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        if (we) begin
          ref_mem[d][a[11:0]] = wdata[8*i +: 8];
          exp_w.push_back({d, a, 24'h0, wdata[8*i +: 8]});
        end else begin
          exp_rd = exp_rd | (32'(ref_mem[d][a[11:0]]) << (8 * i));
        end
      end
      if (!we && n < 4 && !uns && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'h1 << (8 * n)) - 32'h1);
    end
    lat = err ? 1 : n + 1;
    @(negedge clk);
    sel = d;
    chk("ready_idle", 64'(req_ready), 64'(1));
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 20);
    chk("latency", 64'(cyc), 64'(lat));
    chk("resp_err", 64'(resp_err), 64'(err));
    chk("rdata", 64'(resp_rdata), 64'(exp_rd));
    check_writes(exp_w);
    @(negedge clk);
    chk("pulse_end", 64'(resp_valid), 64'(0));
    chk("rdata_hold", 64'(resp_rdata), 64'(exp_rd));
  endtask

  task automatic reset_mid_store();
    logic [64:0] exp_w [$];
    logic        seen;
    ref_mem[0][12'h1FC] = 8'hDD;
    ref_mem[0][12'h1FD] = 8'hCC;
    exp_w.push_back({1'b0, 32'h1FC, 32'hDD});
    exp_w.push_back({1'b0, 32'h1FD, 32'hCC});
    @(negedge clk);
    sel = 1'b0;
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h1FC; req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mem_we", 64'(mem_we0), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(1));
    seen = resp_valid;
    repeat (6) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    chk("rst_no_resp", 64'(seen), 64'(0));
    check_writes(exp_w);
  endtask

  task automatic back_to_back();
    int          acc, busy;
    int          pulses [$];
    logic        drop;
    logic [31:0] exp_rd;
    acc = 0; busy = 0; drop = 1'b0;
    exp_rd = {ref_mem[0][12'h103], ref_mem[0][12'h102], ref_mem[0][12'h101], ref_mem[0][12'h100]};
    @(negedge clk);
    sel = 1'b0;
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100; req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      chk("b2b_ready", 64'(req_ready), 64'(busy == 0));
      if (resp_valid) begin
        pulses.push_back(c);
        chk("b2b_rdata", 64'(resp_rdata), 64'(exp_rd));
      end
      if (busy == 0 && req_valid) begin
        acc++;
        busy = 5;
        drop = (acc == 3);
      end else if (busy > 0) begin
        busy--;
      end
      @(posedge clk);
      #1;
      if (drop) req_valid = 1'b0;
    end
    chk("b2b_pulses", 64'(pulses.size()), 64'(3));
    for (int i = 1; i < pulses.size(); i++) chk("b2b_gap", 64'(pulses[i] - pulses[i-1]), 64'(6));
    chk("b2b_writes", 64'(wlog.size()), 64'(0));
    wlog.delete();
  endtask

  initial begin
    logic        d, we, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4096; i++) ref_mem[m][i] = init_byte(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    init_run = 1'b0;
    chk("rst_ready", 64'(bif0.req_ready), 64'(1));
    chk("rst_resp_valid", 64'(bif0.resp_valid), 64'(0));
    chk("rst_resp_err", 64'(bif0.resp_err), 64'(0));
    chk("rst_rdata", 64'(bif0.resp_rdata), 64'(0));
    chk("rst_mem_we", 64'(mem_we0), 64'(0));
    chk("rst_mem_addr", 64'({mem_ra0, mem_wa0}), 64'(0));
    chk("rst_mem_wd", 64'(mem_wd0), 64'(0));

    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678);
    do_txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    do_txn(1'b0, 1'b1, 2'd0, 1'b0, 32'h104, 32'h00000080);
    do_txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h104, 32'h0);
    do_txn(1'b0, 1'b0, 2'd0, 1'b1, 32'h104, 32'h0);
    do_txn(1'b0, 1'b1, 2'd0, 1'b0, 32'h200, 32'h000000F1);
    do_txn(1'b0, 1'b0, 2'd1, 1'b0, 32'h1FF, 32'h0);
    do_txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h1FF, 32'h0);
    do_txn(1'b1, 1'b1, 2'd2, 1'b0, 32'h102, 32'hDEADBEEF);
    do_txn(1'b1, 1'b1, 2'd1, 1'b0, 32'h100, 32'h0000BEEF);
    do_txn(1'b1, 1'b0, 2'd1, 1'b1, 32'h100, 32'h0);
    do_txn(1'b0, 1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFFFFFF);
    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hCAFEF00D);
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
    reset_mid_store();
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0);
    back_to_back();

    for (int t = 0; t < 80; t++) begin
      d   = ($urandom_range(0, 4) == 0);
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF8 + $urandom_range(0, 7);
      else a = 32'h100 + $urandom_range(0, 255);
      do_txn(d, we, sz, uns, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
